pipeline_hazard_ctrl: RTL

//  Central stall/flush controller for the 5-stage IF/ID/EX/MEM/WB pipeline.

---
 rtl/pipeline_hazard_ctrl_if.sv | 54 +++++
 rtl/pipeline_hazard_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard/stall controller (slave).
// The perf counter outputs exist only when PERF_CNT_EN is defined.
interface pipeline_hazard_ctrl_if #(
  parameter int ID_W  = 7,
  parameter int REG_W = 4
);
  logic             if_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             id_br_taken;
  logic             ex_is_load;
  logic [REG_W-1:0] ex_rd;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             stall;
  logic             flush;
  logic [4:0]       stage_valid;
  logic [ID_W-1:0]  if_tag;
  logic [ID_W-1:0]  id_tag;
  logic [ID_W-1:0]  ex_tag;
  logic [ID_W-1:0]  mem_tag;
  logic [ID_W-1:0]  wb_tag;
  logic             wb_retire;
  logic             stall_err;
`ifdef PERF_CNT_EN
  logic [31:0]      perf_cyc;
  logic [31:0]      perf_ret;
  logic [31:0]      perf_stl;
  logic [31:0]      perf_fls;
`endif

  modport master (
    output if_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_br_taken, ex_is_load, ex_rd,
    input  pc_en, ifid_en, ifid_flush, idex_flush, stall, flush, stage_valid,
           if_tag, id_tag, ex_tag, mem_tag, wb_tag, wb_retire, stall_err
`ifdef PERF_CNT_EN
    , input perf_cyc, perf_ret, perf_stl, perf_fls
`endif
  );

  modport slave (
    input  if_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_br_taken, ex_is_load, ex_rd,
    output pc_en, ifid_en, ifid_flush, idex_flush, stall, flush, stage_valid,
           if_tag, id_tag, ex_tag, mem_tag, wb_tag, wb_retire, stall_err
`ifdef PERF_CNT_EN
    , output perf_cyc, perf_ret, perf_stl, perf_fls
`endif
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for a 5-stage pipeline with per-stage sequence tags down to WB.
// Optional PERF_CNT_EN adds saturating cycle/retire/stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int ID_W  = 7,
  parameter int REG_W = 4,
  parameter int WDOG  = 16
) (
  input  logic clk,
  input  logic rst,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(WDOG + 1);

  logic             v_id_reg, v_ex_reg, v_mem_reg, v_wb_reg;
  logic [ID_W-1:0]  id_tag_reg, ex_tag_reg, mem_tag_reg, wb_tag_reg;
  logic [ID_W-1:0]  seq_cnt_reg;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic             stall_err_reg;

  logic rs1_hit, rs2_hit, hazard, br_flush, fetch_take, wdog_hit;

  always_comb begin
    rs1_hit    = bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd);
    rs2_hit    = bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd);
    hazard     = v_id_reg && v_ex_reg && bus.ex_is_load && (bus.ex_rd != '0) && (rs1_hit || rs2_hit);
    // A branch waiting on a load operand is held; it flushes on the first free cycle.
    br_flush   = v_id_reg && bus.id_br_taken && !hazard;
    fetch_take = bus.if_valid && !br_flush;
    wdog_hit   = hazard && (stall_cnt_reg == CNT_W'(WDOG - 1));
  end

  assign bus.stall       = hazard;
  assign bus.flush       = br_flush;
  assign bus.pc_en       = !hazard;
  assign bus.ifid_en     = !hazard;
  assign bus.idex_flush  = hazard;
  assign bus.ifid_flush  = br_flush;
  assign bus.stage_valid = {v_wb_reg, v_mem_reg, v_ex_reg, v_id_reg, bus.if_valid};
  assign bus.if_tag      = seq_cnt_reg;
  assign bus.id_tag      = id_tag_reg;
  assign bus.ex_tag      = ex_tag_reg;
  assign bus.mem_tag     = mem_tag_reg;
  assign bus.wb_tag      = wb_tag_reg;
  assign bus.wb_retire   = v_wb_reg;
  assign bus.stall_err   = stall_err_reg | wdog_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_id_reg      <= 1'b0;
      v_ex_reg      <= 1'b0;
      v_mem_reg     <= 1'b0;
      v_wb_reg      <= 1'b0;
      id_tag_reg    <= '0;
      ex_tag_reg    <= '0;
      mem_tag_reg   <= '0;
      wb_tag_reg    <= '0;
      seq_cnt_reg   <= '0;
      stall_cnt_reg <= '0;
      stall_err_reg <= 1'b0;
    end else begin
      v_wb_reg    <= v_mem_reg;
      wb_tag_reg  <= mem_tag_reg;
      v_mem_reg   <= v_ex_reg;
      mem_tag_reg <= ex_tag_reg;
      if (hazard) begin
        v_ex_reg <= 1'b0;
        if (stall_cnt_reg != CNT_W'(WDOG - 1))
          stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end else begin
        v_ex_reg      <= v_id_reg;
        ex_tag_reg    <= id_tag_reg;
        v_id_reg      <= fetch_take;
        id_tag_reg    <= seq_cnt_reg;
        stall_cnt_reg <= '0;
        // Squashed fetches do not consume a sequence ID.
        if (fetch_take)
          seq_cnt_reg <= seq_cnt_reg + ID_W'(1);
      end
      if (wdog_hit)
        stall_err_reg <= 1'b1;
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] perf_cyc_reg, perf_ret_reg, perf_stl_reg, perf_fls_reg;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic en);
    return (en && (val != 32'hFFFF_FFFF)) ? val + 32'd1 : val;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cyc_reg <= '0;
      perf_ret_reg <= '0;
      perf_stl_reg <= '0;
      perf_fls_reg <= '0;
    end else begin
      perf_cyc_reg <= sat_inc(perf_cyc_reg, 1'b1);
      perf_ret_reg <= sat_inc(perf_ret_reg, v_wb_reg);
      perf_stl_reg <= sat_inc(perf_stl_reg, hazard);
      perf_fls_reg <= sat_inc(perf_fls_reg, br_flush);
    end
  end

  assign bus.perf_cyc = perf_cyc_reg;
  assign bus.perf_ret = perf_ret_reg;
  assign bus.perf_stl = perf_stl_reg;
  assign bus.perf_fls = perf_fls_reg;
`endif
endmodule
